// File: rtl/sram_uart_writer.sv
// sram_uart_writer: packs UART bytes into 16-bit words, queues them in a small
// FIFO and writes them to sequential SRAM addresses during VGA blanking.
//
// state | meaning
// IDLE  | bus released; waits for a buffered word and blanking
// SETUP | bus owned, address/data driven, WE_N high
// WRITE | WE_N low for WE_CYCLES cycles
// HOLD  | WE_N high, data still driven; pointer advances on exit
module sram_uart_writer #(
  parameter int ADDR_W      = 20,
  parameter int FRAME_WORDS = 307200,
  parameter int FIFO_DEPTH  = 4,
  parameter int WE_CYCLES   = 2
) (
  input  logic                            pixel_clk,
  input  logic                            nRST,
  input  logic [7:0]                      rx_data,
  input  logic                            rx_valid,
  input  logic                            addr_clr,
  input  logic                            blank_n,
  output logic [ADDR_W-1:0]               SRAM_ADDR,
  output logic [15:0]                     SRAM_DQ_out,
  output logic                            SRAM_DQ_oe,
  output logic                            SRAM_WE_N,
  output logic                            SRAM_CE_N,
  output logic                            SRAM_UB_N,
  output logic                            SRAM_LB_N,
  output logic                            wr_active,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_level,
  output logic                            overflow
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int CNT_W = (WE_CYCLES > 1) ? $clog2(WE_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, SETUP, WRITE, HOLD} stateT;

  stateT              state;
  logic               hasLow;
  logic [7:0]         lowByte;
  logic               pushValid;
  logic [15:0]        pushData;
  logic [15:0]        mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wrPtr;
  logic [PTR_W-1:0]   rdPtr;
  logic [LVL_W-1:0]   level;
  logic               fifoFull;
  logic               fifoEmpty;
  logic               pop;
  logic               accept;
  logic               clrPending;
  logic [CNT_W-1:0]   weCnt;
  logic [ADDR_W-1:0]  addrPtr;

  assign fifoFull   = (level == LVL_W'(FIFO_DEPTH));
  assign fifoEmpty  = (level == '0);
  // addr_clr in IDLE wins over a pop so the flushed FIFO is never read
  assign pop        = (state == IDLE) && !fifoEmpty && !blank_n && !addr_clr;
  assign accept     = pushValid && (!fifoFull || pop) && !addr_clr;
  assign fifo_level = level;
  assign SRAM_ADDR  = addrPtr;

  // Byte packer: low byte first, completed word pushed one cycle after the strobe
  always_ff @(posedge pixel_clk or negedge nRST) begin
    if (!nRST) begin
      hasLow    <= 1'b0;
      lowByte   <= '0;
      pushValid <= 1'b0;
      pushData  <= '0;
    end else begin
      pushValid <= 1'b0;
      if (addr_clr) begin
        hasLow <= 1'b0;
      end else if (rx_valid) begin
        if (!hasLow) begin
          lowByte <= rx_data;
          hasLow  <= 1'b1;
        end else begin
          pushData  <= {rx_data, lowByte};
          pushValid <= 1'b1;
          hasLow    <= 1'b0;
        end
      end
    end
  end

  // FIFO storage; contents need no reset since level gates every read
  always_ff @(posedge pixel_clk) begin
    if (accept) mem[wrPtr] <= pushData;
  end

  // FIFO pointers, level and sticky overflow
  always_ff @(posedge pixel_clk or negedge nRST) begin
    if (!nRST) begin
      wrPtr    <= '0;
      rdPtr    <= '0;
      level    <= '0;
      overflow <= 1'b0;
    end else if (addr_clr) begin
      wrPtr    <= '0;
      rdPtr    <= '0;
      level    <= '0;
      overflow <= 1'b0;
    end else begin
      if (accept) wrPtr <= wrPtr + PTR_W'(1);
      if (pop)    rdPtr <= rdPtr + PTR_W'(1);
      if (accept && !pop)      level <= level + LVL_W'(1);
      else if (!accept && pop) level <= level - LVL_W'(1);
      if (pushValid && fifoFull && !pop) overflow <= 1'b1;
    end
  end

  // Write sequencer with registered SRAM controls and write pointer
  always_ff @(posedge pixel_clk or negedge nRST) begin
    if (!nRST) begin
      state       <= IDLE;
      SRAM_DQ_out <= '0;
      SRAM_DQ_oe  <= 1'b0;
      SRAM_WE_N   <= 1'b1;
      SRAM_CE_N   <= 1'b1;
      SRAM_UB_N   <= 1'b1;
      SRAM_LB_N   <= 1'b1;
      wr_active   <= 1'b0;
      weCnt       <= '0;
      addrPtr     <= '0;
      clrPending  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (addr_clr) begin
            addrPtr <= '0;
          end else if (pop) begin
            SRAM_DQ_out <= mem[rdPtr];
            SRAM_DQ_oe  <= 1'b1;
            SRAM_WE_N   <= 1'b1;
            SRAM_CE_N   <= 1'b0;
            SRAM_UB_N   <= 1'b0;
            SRAM_LB_N   <= 1'b0;
            wr_active   <= 1'b1;
            state       <= SETUP;
          end
        end
        SETUP: begin
          if (addr_clr) clrPending <= 1'b1;
          SRAM_WE_N <= 1'b0;
          weCnt     <= CNT_W'(WE_CYCLES - 1);
          state     <= WRITE;
        end
        WRITE: begin
          if (addr_clr) clrPending <= 1'b1;
          if (weCnt == '0) begin
            SRAM_WE_N <= 1'b1;
            state     <= HOLD;
          end else begin
            weCnt <= weCnt - CNT_W'(1);
          end
        end
        HOLD: begin
          // a clear seen during the write lands here instead of the increment
          if (addr_clr || clrPending)                addrPtr <= '0;
          else if (addrPtr == ADDR_W'(FRAME_WORDS - 1)) addrPtr <= '0;
          else                                       addrPtr <= addrPtr + ADDR_W'(1);
          clrPending <= 1'b0;
          SRAM_DQ_oe <= 1'b0;
          SRAM_CE_N  <= 1'b1;
          SRAM_UB_N  <= 1'b1;
          SRAM_LB_N  <= 1'b1;
          wr_active  <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/sram_uart_writer.md
Name: sram_uart_writer

Overview:
- Write-side counterpart to the VGA SRAM read path.
- Packs UART-received bytes into 16-bit words and buffers them in a small FIFO.
- Writes each word to the DE2-115 SRAM at sequential addresses, only while the VGA blanking signal shows the bus is free of display reads.
- The top level muxes SRAM address and control between this block and the VGA reader using wr_active.

Parameters:
- ADDR_W, 20, SRAM word-address width.
- FRAME_WORDS, 307200, number of words in one frame buffer; the address wraps to 0 after FRAME_WORDS-1.
- FIFO_DEPTH, 4, word FIFO depth; power of two, minimum 2.
- WE_CYCLES, 2, number of cycles SRAM_WE_N is held low per write.

Ports:
- pixel_clk  in  1  system/pixel clock; all logic on rising edge.
- nRST  in  1  asynchronous active-low reset.
- rx_data  in  8  received UART byte.
- rx_valid  in  1  one-cycle strobe; rx_data is valid in this cycle.
- addr_clr  in  1  one-cycle pulse: restart at address 0, drop the partial byte, flush the FIFO, clear overflow.
- blank_n  in  1  VGA_BLANK_N; a write may start only when it is 0.
- SRAM_ADDR  out  ADDR_W  write address.
- SRAM_DQ_out  out  16  write data.
- SRAM_DQ_oe  out  1  1 = top drives SRAM_DQ with SRAM_DQ_out.
- SRAM_WE_N  out  1  SRAM write enable, active low.
- SRAM_CE_N  out  1  low while wr_active.
- SRAM_UB_N, SRAM_LB_N  out  1 each  low while wr_active (full-word writes).
- wr_active  out  1  this block owns the SRAM bus.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  number of words buffered.
- overflow  out  1  sticky: a completed word was dropped because the FIFO was full.

Behaviour:
- Reset values: SRAM_ADDR=0, SRAM_DQ_out=0, SRAM_DQ_oe=0, SRAM_WE_N=1, SRAM_CE_N=1, SRAM_UB_N=1, SRAM_LB_N=1, wr_active=0, fifo_level=0, overflow=0. Packer is empty and the FSM is in IDLE.
- Reset applies immediately, including mid-write. Because SRAM_WE_N goes high asynchronously, a torn write is acceptable.
- Packer:
  - The first rx_valid byte is latched as the low byte.
  - The second rx_valid byte forms the word {second, first}, which is pushed to the FIFO in the cycle after the strobe.
- FIFO:
  - Push and pop in the same cycle are both honoured; fifo_level is unchanged.
  - A push while full (with no pop that cycle) drops the word and sets overflow=1.
  - A push to an empty FIFO is not visible to the FSM until the next cycle (no bypass).
- FSM states:
  - IDLE: if FIFO non-empty and blank_n==0, pop the head into SRAM_DQ_out and go to SETUP; otherwise stay.
  - SETUP (1 cycle): wr_active=1, CE/UB/LB low, SRAM_DQ_oe=1, SRAM_WE_N=1; SRAM_ADDR holds the write pointer.
  - WRITE (WE_CYCLES cycles): SRAM_WE_N=0; address and data stable.
  - HOLD (1 cycle): SRAM_WE_N=1 with data still driven. Then:
    - the write pointer increments, wrapping FRAME_WORDS-1 -> 0;
    - go to IDLE, where wr_active=0, SRAM_DQ_oe=0 and CE/UB/LB return high.
- Per-word timing: one write takes WE_CYCLES+2 cycles. Back-to-back words are separated by one IDLE cycle.
- A write in progress always completes even if blank_n rises. The top level gives wr_active priority over the reader; display corruption is bounded to WE_CYCLES+2 pixels.
- addr_clr:
  - In IDLE: takes effect next cycle.
  - During SETUP, WRITE or HOLD: the current write completes at its old address, then the pointer is set to 0 rather than incremented.
  - rx_valid coinciding with addr_clr: the byte is discarded.
- Simultaneous rx_valid completing a word and a pop in IDLE: both are honoured.

Test Plan:
- Reset, then rx bytes 0x34 then 0x12 with blank_n=0 -> one write: SRAM_ADDR=0, SRAM_DQ_out=0x1234; SRAM_WE_N low for exactly 2 cycles, framed by one SETUP and one HOLD cycle; pointer advances to 1.
- blank_n=1 held while 3 words are received -> no SRAM_WE_N activity and fifo_level=3; drop blank_n -> three writes to addresses 0, 1, 2 with one IDLE cycle between them.
- Receive 6 words with blank_n=1 and FIFO_DEPTH=4 -> fifo_level=4, overflow=1; the first four words are written once blanking opens.
- Preset the pointer to FRAME_WORDS-1 (via 307199 writes, or FRAME_WORDS=8 in a reduced build), then write two words -> addresses FRAME_WORDS-1, then 0.
- Assert blank_n=1 during WRITE -> the write completes unchanged and the next FIFO word waits for blank_n=0.
- Single byte 0xAA, then addr_clr, then bytes 0x01, 0x02 -> word 0x0201 written at address 0; 0xAA never appears. Also: deassert nRST during WRITE -> SRAM_WE_N=1 and wr_active=0 immediately.
